// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the dmem arbiter: access-type encodings, lock FSM states,
// and the alignment check used on the granted request.
package dmem_arbiter_pkg;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  typedef enum logic {
    ST_RR    = 1'b0,
    ST_LOCK1 = 1'b1
  } lock_state_e;

  function automatic logic is_misaligned(input logic [2:0] rw_type, input logic [1:0] addr_lo);
    case (rw_type)
      RW_H, RW_HU: return addr_lo[0];
      RW_W:        return (addr_lo != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter with force overrides; purely combinational one-hot grant.
// Forces only matter on a tie; a lone request is always granted.
module dmem_arbiter_rr_arb2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_gnt,
  input  logic       force0,
  input  logic       force1,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
      if (force0)        gnt = 2'b01;
      else if (force1)   gnt = 2'b10;
      else if (last_gnt) gnt = 2'b01;
      else               gnt = 2'b10;
    end else if (req0) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares dmem between core (port 0) and loader/DMA (port 1): one access/cycle, response 1 cycle after grant.
// No backpressure beyond gnt: requesters hold their request until granted.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 8,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [2:0]    rwtype0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  output logic          err0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [2:0]    rwtype1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          err1,
  input  logic          lock1,
  output logic          mem_w_en,
  output logic          mem_r_en,
  output logic [AW-1:0] mem_addr,
  output logic [2:0]    mem_rw_type,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic [CW-1:0] conflict_cnt
);

  localparam int LCW = $clog2(MAX_LOCK + 1);

  lock_state_e    state_q, state_d;
  logic           last_gnt_q, last_gnt_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic           rvalid0_q, rvalid1_q;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic           err_q, err_d;
  logic [CW-1:0]  conflict_q, conflict_d;

  logic [1:0] arb_gnt;
  logic       force0, force1, sel_we, misal, any_gnt;

  // In LOCK1 port 1 wins ties until it has used its budget, then port 0 is forced in once.
  assign force0 = (state_q == ST_LOCK1) && (lock_cnt_q == LCW'(MAX_LOCK));
  assign force1 = (state_q == ST_LOCK1) && !force0;

  dmem_arbiter_rr_arb2 u_arb (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt_q),
    .force0   (force0),
    .force1   (force1),
    .gnt      (arb_gnt)
  );

  assign gnt0    = rst_n & arb_gnt[0];
  assign gnt1    = rst_n & arb_gnt[1];
  assign any_gnt = gnt0 | gnt1;

  always_comb begin
    mem_addr    = arb_gnt[1] ? addr1   : addr0;
    mem_din     = arb_gnt[1] ? wdata1  : wdata0;
    mem_rw_type = arb_gnt[1] ? rwtype1 : rwtype0;
    sel_we      = arb_gnt[1] ? we1     : we0;
  end

  assign misal    = is_misaligned(mem_rw_type, mem_addr[1:0]);
  assign mem_w_en = any_gnt & !misal & sel_we;
  assign mem_r_en = any_gnt & !misal & !sel_we;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    lock_cnt_d = lock_cnt_q;
    conflict_d = conflict_q;
    rdata_d    = (mem_r_en) ? mem_dout : '0;
    err_d      = any_gnt & misal;

    case (state_q)
      ST_RR:    if (gnt1 && lock1) state_d = ST_LOCK1;
      ST_LOCK1: if (!req1 || (gnt1 && !lock1) || (gnt0 && force0)) state_d = ST_RR;
      default:  state_d = ST_RR;
    endcase

    if (gnt1)      last_gnt_d = 1'b1;
    else if (gnt0) last_gnt_d = 1'b0;

    // The grant that enters LOCK1 already counts toward the budget.
    if (state_d == ST_LOCK1 && gnt1 && req0 && lock_cnt_q != LCW'(MAX_LOCK))
      lock_cnt_d = lock_cnt_q + LCW'(1);
    else if (gnt0 || state_d == ST_RR)
      lock_cnt_d = '0;

    if (req0 && req1 && conflict_q != {CW{1'b1}})
      conflict_d = conflict_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RR;
      last_gnt_q <= 1'b1;
      lock_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      conflict_q <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid0_q  <= gnt0;
      rvalid1_q  <= gnt1;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      conflict_q <= conflict_d;
    end
  end

  assign rvalid0      = rst_n & rvalid0_q;
  assign rvalid1      = rst_n & rvalid1_q;
  assign rdata0       = rvalid0 ? rdata_q : '0;
  assign rdata1       = rvalid1 ? rdata_q : '0;
  assign err0         = rvalid0 & err_q;
  assign err1         = rvalid1 & err_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a simple word-addressed dmem model;
// a second instance with CW=4 shares the stimulus for counter saturation.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, we0, req1, we1, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [2:0]  rwtype0, rwtype1;
  logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_w_en, mem_r_en;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic [2:0]  mem_rw_type;
  logic [15:0] conflict_cnt;

  logic        s_gnt0, s_rvalid0, s_err0, s_gnt1, s_rvalid1, s_err1;
  logic [31:0] s_rdata0, s_rdata1, s_mem_addr, s_mem_din;
  logic        s_mem_w_en, s_mem_r_en;
  logic [2:0]  s_mem_rw_type;
  logic [3:0]  s_conflict_cnt;

  logic [31:0] mem [0:63];
  int n_checks, n_fail;

  always #5 clk = ~clk;

  initial for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
  always @(posedge clk) if (mem_w_en) mem[mem_addr[7:2]] <= mem_din;
  assign mem_dout = mem[mem_addr[7:2]];

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .rwtype0(rwtype0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .rwtype1(rwtype1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .err1(err1),
    .lock1(lock1), .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .mem_addr(mem_addr),
    .mem_rw_type(mem_rw_type), .mem_din(mem_din), .mem_dout(mem_dout),
    .conflict_cnt(conflict_cnt)
  );

  dmem_arbiter #(.CW(4)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .rwtype0(rwtype0), .wdata0(wdata0),
    .gnt0(s_gnt0), .rvalid0(s_rvalid0), .rdata0(s_rdata0), .err0(s_err0),
    .req1(req1), .we1(we1), .addr1(addr1), .rwtype1(rwtype1), .wdata1(wdata1),
    .gnt1(s_gnt1), .rvalid1(s_rvalid1), .rdata1(s_rdata1), .err1(s_err1),
    .lock1(lock1), .mem_w_en(s_mem_w_en), .mem_r_en(s_mem_r_en), .mem_addr(s_mem_addr),
    .mem_rw_type(s_mem_rw_type), .mem_din(s_mem_din), .mem_dout(mem_dout),
    .conflict_cnt(s_conflict_cnt)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1;
    #1;
    n_checks++;
    if ({gnt0, gnt1, mem_w_en, mem_r_en} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_gnt_en: got %b expected 0000", {gnt0, gnt1, mem_w_en, mem_r_en});
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({rvalid0, rvalid1, err0, err1} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_resp: got %b expected 0000", {rvalid0, rvalid1, err0, err1});
    end
    n_checks++;
    if ({rdata0, rdata1} !== 64'h0) begin
      n_fail++; $display("FAIL rst_rdata: got %h expected 0", {rdata0, rdata1});
    end
    n_checks++;
    if (conflict_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rst_conflict: got %0d expected 0", conflict_cnt);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; rwtype0 = 3'b010; wdata0 = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if ({gnt0, gnt1, mem_w_en, mem_r_en} !== 4'b1010) begin
      n_fail++; $display("FAIL wr_grant: got %b expected 1010", {gnt0, gnt1, mem_w_en, mem_r_en});
    end
    n_checks++;
    if ({mem_addr, mem_din} !== {32'h10, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL wr_bus: got %h/%h expected 10/deadbeef", mem_addr, mem_din);
    end
    @(negedge clk);
    we0 = 1'b0;
    #1;
    n_checks++;
    if ({gnt0, mem_r_en, mem_w_en} !== 3'b110) begin
      n_fail++; $display("FAIL rd_grant: got %b expected 110", {gnt0, mem_r_en, mem_w_en});
    end
    n_checks++;
    if ({rvalid0, err0, rvalid1, rdata0} !== {3'b100, 32'h0}) begin
      n_fail++; $display("FAIL wr_resp: got %b %h expected 100 0", {rvalid0, err0, rvalid1}, rdata0);
    end
    @(negedge clk);
    req0 = 1'b0;
    #1;
    n_checks++;
    if ({rvalid0, err0, rdata0} !== {2'b10, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL rd_resp: got %b %h expected 10 deadbeef", {rvalid0, err0}, rdata0);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (rvalid0 !== 1'b0) begin
      n_fail++; $display("FAIL rvalid_one_cycle: got %b expected 0", rvalid0);
    end
  endtask

  task automatic test_alternate();
    logic e0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20; rwtype0 = 3'b010;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h24; rwtype1 = 3'b010; lock1 = 1'b0;
      end
      #1;
      e0 = (i % 2 == 0);
      n_checks++;
      if ({gnt0, gnt1} !== {e0, !e0}) begin
        n_fail++; $display("FAIL alt_gnt[%0d]: got %b expected %b", i, {gnt0, gnt1}, {e0, !e0});
      end
      n_checks++;
      if (conflict_cnt !== 16'(i)) begin
        n_fail++; $display("FAIL alt_conflict[%0d]: got %0d expected %0d", i, conflict_cnt, i);
      end
      n_checks++;
      if (mem_addr !== (e0 ? 32'h20 : 32'h24)) begin
        n_fail++; $display("FAIL alt_addr[%0d]: got %h", i, mem_addr);
      end
      if (i > 0) begin
        n_checks++;
        if ({rvalid0, rvalid1, rdata0, rdata1} !==
            {!e0, e0, (e0 ? 32'h0 : 32'h1000_0008), (e0 ? 32'h1000_0009 : 32'h0)}) begin
          n_fail++; $display("FAIL alt_resp[%0d]: got %b %h %h", i, {rvalid0, rvalid1}, rdata0, rdata1);
        end
      end
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_lock();
    logic [13:0] exp1;
    exp1 = 14'b01110111111110;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i == 0) begin
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20; rwtype0 = 3'b010;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h24; rwtype1 = 3'b010; lock1 = 1'b1;
      end
      if (i == 12) lock1 = 1'b0;
      #1;
      n_checks++;
      if ({gnt0, gnt1} !== {!exp1[i], exp1[i]}) begin
        n_fail++; $display("FAIL lock_gnt[%0d]: got %b expected %b", i, {gnt0, gnt1}, {!exp1[i], exp1[i]});
      end
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h13; rwtype1 = 3'b001;
    #1;
    n_checks++;
    if ({gnt1, gnt0, mem_r_en, mem_w_en} !== 4'b1000) begin
      n_fail++; $display("FAIL mis_lh_grant: got %b expected 1000", {gnt1, gnt0, mem_r_en, mem_w_en});
    end
    @(negedge clk);
    addr1 = 32'h22; rwtype1 = 3'b010;
    #1;
    n_checks++;
    if ({gnt1, mem_r_en} !== 2'b10) begin
      n_fail++; $display("FAIL mis_lw_grant: got %b expected 10", {gnt1, mem_r_en});
    end
    n_checks++;
    if ({rvalid1, err1, rvalid0, rdata1} !== {3'b110, 32'h0}) begin
      n_fail++; $display("FAIL mis_lh_resp: got %b %h expected 110 0", {rvalid1, err1, rvalid0}, rdata1);
    end
    @(negedge clk);
    addr1 = 32'h24;
    #1;
    n_checks++;
    if ({gnt1, mem_r_en, rvalid1, err1, rdata1} !== {4'b1111, 32'h0}) begin
      n_fail++; $display("FAIL mis_lw_resp: got %b %h expected 1111 0", {gnt1, mem_r_en, rvalid1, err1}, rdata1);
    end
    @(negedge clk);
    addr1 = 32'h22; rwtype1 = 3'b101;
    #1;
    n_checks++;
    if ({gnt1, mem_r_en, rvalid1, err1, rdata1} !== {4'b1110, 32'h1000_0009}) begin
      n_fail++; $display("FAIL al_lw_resp: got %b %h expected 1110 10000009", {gnt1, mem_r_en, rvalid1, err1}, rdata1);
    end
    @(negedge clk);
    req1 = 1'b0;
    #1;
    n_checks++;
    if ({rvalid1, err1, rdata1} !== {2'b10, 32'h1000_0008}) begin
      n_fail++; $display("FAIL al_lhu_resp: got %b %h expected 10 10000008", {rvalid1, err1}, rdata1);
    end
  endtask

  task automatic test_reset_pending();
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20; rwtype0 = 3'b010;
    #1;
    n_checks++;
    if (gnt0 !== 1'b1) begin
      n_fail++; $display("FAIL pend_gnt0: got %b expected 1", gnt0);
    end
    @(negedge clk);
    req0 = 1'b0; rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rvalid0, mem_r_en, rdata0} !== 34'h0) begin
      n_fail++; $display("FAIL pend_drop: got %b %h expected 00 0", {rvalid0, mem_r_en}, rdata0);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_w_en, mem_r_en, conflict_cnt} !== 24'h0) begin
      n_fail++; $display("FAIL pend_rst_outputs: got %b cnt %0d expected all 0",
                         {gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_w_en, mem_r_en}, conflict_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1; req0 = 1'b1; req1 = 1'b1; lock1 = 1'b0;
    addr1 = 32'h24; rwtype1 = 3'b010; we1 = 1'b0;
    #1;
    n_checks++;
    if ({gnt0, gnt1, rvalid0} !== 3'b100) begin
      n_fail++; $display("FAIL pend_tie: got %b expected 100", {gnt0, gnt1, rvalid0});
    end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; lock1 = 1'b0;
    repeat (20) @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    #1;
    n_checks++;
    if (s_conflict_cnt !== 4'hF) begin
      n_fail++; $display("FAIL sat_cw4: got %0d expected 15", s_conflict_cnt);
    end
    n_checks++;
    if (conflict_cnt !== 16'd20) begin
      n_fail++; $display("FAIL sat_cw16: got %0d expected 20", conflict_cnt);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; lock1 = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; rwtype0 = 3'b010; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; rwtype1 = 3'b010; wdata1 = '0;
    test_reset();
    test_write_read();
    test_alternate();
    test_lock();
    test_misaligned();
    test_reset_pending();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
